// File: rtl/vector_abs_pkg.sv
// rtl/vector_abs_pkg.sv - shared constants, result type and saturation helper for vector_abs
//
// Contents:
//   VECTOR_ABS_W      default component/result width (32)
//   VECTOR_ABS_MAX_W  widest WIDTH the saturation helper can describe
//   vector_abs_res_t  result record at the default width (abs, ovf)
//   vector_abs_sat_value(width)  all-ones saturation value for a given width

package vector_abs_pkg;

  localparam int unsigned VECTOR_ABS_W     = 32;
  localparam int unsigned VECTOR_ABS_MAX_W = 64;

  typedef struct packed {
    logic [VECTOR_ABS_W-1:0] abs;
    logic                    ovf;
  } vector_abs_res_t;

  // Returns 2^width - 1 in a fixed-size container; callers take the low
  // `width` bits. Widths at or above the container size give all ones.
  function automatic logic [VECTOR_ABS_MAX_W-1:0] vector_abs_sat_value(input int unsigned width);
    logic [VECTOR_ABS_MAX_W-1:0] ones;
    ones = '1;
    if (width >= VECTOR_ABS_MAX_W) begin
      return ones;
    end
    return (ones >> (VECTOR_ABS_MAX_W - width));
  endfunction

endpackage : vector_abs_pkg

// File: rtl/vector_abs_minmax.sv
// rtl/vector_abs_minmax.sv - combinational unsigned max/min selector
//
// Ports:
//   x_i    in  WIDTH  first operand, unsigned
//   y_i    in  WIDTH  second operand, unsigned
//   max_o  out WIDTH  larger operand (x_i on a tie)
//   min_o  out WIDTH  smaller operand (y_i on a tie)

module minmax
  import vector_abs_pkg::*;
#(
  parameter int unsigned WIDTH = VECTOR_ABS_W
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_o
);

  logic x_lt_y;

  // Strict less-than so equal operands route x to max.
  assign x_lt_y = (x_i < y_i);

  always_comb begin
    max_o = x_i;
    min_o = y_i;
    if (x_lt_y) begin
      max_o = y_i;
      min_o = x_i;
    end
  end

endmodule : minmax

// File: rtl/vector_abs.sv
// rtl/vector_abs.sv - registered alpha-max-plus-beta-min magnitude estimate, max + min/2
//
// Ports:
//   clk_i    in  1      clock, rising edge
//   rst_ni   in  1      asynchronous active-low reset
//   valid_i  in  1      x/y pair valid this cycle (always accepted)
//   x        in  WIDTH  first component, unsigned
//   y        in  WIDTH  second component, unsigned
//   valid_o  out 1      abs holds a new result this cycle
//   abs      out WIDTH  magnitude estimate
//   ovf_o    out 1      carry-out of the full-precision sum for the current result
//
// Build option: define VECTOR_ABS_SAT_EN to clamp abs to all ones on carry-out;
// otherwise abs wraps modulo 2^WIDTH. ovf_o is the same in both builds.

module vector_abs
  import vector_abs_pkg::*;
#(
  parameter int unsigned WIDTH = VECTOR_ABS_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             valid_o,
  output logic [WIDTH-1:0] abs,
  output logic             ovf_o
);

  logic [WIDTH-1:0] max_w;
  logic [WIDTH-1:0] min_w;
  logic [WIDTH-1:0] half_min;
  logic [WIDTH:0]   sum_full;
  logic             carry;

  logic [WIDTH-1:0] abs_d, abs_q;
  logic             ovf_d, ovf_q;
  logic             valid_d, valid_q;

  minmax #(
    .WIDTH (WIDTH)
  ) u_minmax (
    .x_i   (x),
    .y_i   (y),
    .max_o (max_w),
    .min_o (min_w)
  );

  // Logical shift: min/2 truncates toward zero.
  assign half_min = min_w >> 1;
  assign sum_full = {1'b0, max_w} + {1'b0, half_min};
  assign carry    = sum_full[WIDTH];

`ifdef VECTOR_ABS_SAT_EN
  localparam logic [VECTOR_ABS_MAX_W-1:0] SAT_FULL = vector_abs_sat_value(WIDTH);
  localparam logic [WIDTH-1:0]            SAT_VAL  = SAT_FULL[WIDTH-1:0];

  always_comb begin
    abs_d = sum_full[WIDTH-1:0];
    if (carry) begin
      abs_d = SAT_VAL;
    end
  end
`else
  always_comb begin
    abs_d = sum_full[WIDTH-1:0];
  end
`endif

  assign ovf_d   = carry;
  assign valid_d = valid_i;

  // Result registers only load on an accepted pair, so abs/ovf_o hold
  // through idle cycles while valid_o drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      abs_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (valid_i) begin
        abs_q <= abs_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign abs     = abs_q;
  assign ovf_o   = ovf_q;
  assign valid_o = valid_q;

endmodule : vector_abs

// File: tb/tb_vector_abs.sv
// tb/tb_vector_abs.sv - directed self-checking bench for vector_abs

module tb_vector_abs;
  import vector_abs_pkg::*;

  localparam int W = VECTOR_ABS_W;

  logic         clk_s;
  logic         rst_ns;
  logic         valid_is;
  logic [W-1:0] x_s;
  logic [W-1:0] y_s;
  logic         valid_os;
  logic [W-1:0] abs_s;
  logic         ovf_os;

  int errors;
  int checks;

  vector_abs #(
    .WIDTH (W)
  ) dut (
    .clk_i   (clk_s),
    .rst_ni  (rst_ns),
    .valid_i (valid_is),
    .x       (x_s),
    .y       (y_s),
    .valid_o (valid_os),
    .abs     (abs_s),
    .ovf_o   (ovf_os)
  );

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  // Drive on the falling edge, then step past the next rising edge.
  task automatic drive(input logic v, input logic [W-1:0] xv, input logic [W-1:0] yv);
    @(negedge clk_s);
    valid_is = v;
    x_s      = xv;
    y_s      = yv;
    @(posedge clk_s);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'd3, 32'd4);
    #2;
    rst_ns = 1'b0;
    #1;
    checks++;
    if (valid_os !== 1'b0) begin errors++; $display("FAIL reset_valid_immediate: got %0b want 0", valid_os); end
    checks++;
    if (abs_s !== 32'd0) begin errors++; $display("FAIL reset_abs_immediate: got %h want 0", abs_s); end
    checks++;
    if (ovf_os !== 1'b0) begin errors++; $display("FAIL reset_ovf_immediate: got %0b want 0", ovf_os); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_s);
      #1;
      checks++;
      if (valid_os !== 1'b0 || abs_s !== 32'd0 || ovf_os !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: valid=%0b abs=%h ovf=%0b want 0 0 0", valid_os, abs_s, ovf_os);
      end
    end
    @(negedge clk_s);
    valid_is = 1'b0;
    rst_ns   = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] tx [5];
    logic [W-1:0] ty [5];
    logic [W-1:0] te [5];
    tx = '{32'd0, 32'd1, 32'd3, 32'd4, 32'd10};
    ty = '{32'd0, 32'd1, 32'd4, 32'd3, 32'd7};
    te = '{32'd0, 32'd1, 32'd5, 32'd5, 32'd13};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, tx[i], ty[i]);
      checks++;
      if (abs_s !== te[i] || ovf_os !== 1'b0 || valid_os !== 1'b1) begin
        errors++;
        $display("FAIL basic(%0d,%0d): abs=%0d ovf=%0b valid=%0b want abs=%0d ovf=0 valid=1",
                 tx[i], ty[i], abs_s, ovf_os, valid_os, te[i]);
      end
    end
  endtask

  task automatic test_overflow();
    vector_abs_res_t exp_r;
`ifdef VECTOR_ABS_SAT_EN
    exp_r = '{abs: 32'hFFFF_FFFF, ovf: 1'b1};
`else
    exp_r = '{abs: 32'h7FFF_FFFE, ovf: 1'b1};
`endif
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (abs_s !== exp_r.abs) begin errors++; $display("FAIL overflow_abs: got %h want %h", abs_s, exp_r.abs); end
    checks++;
    if (ovf_os !== exp_r.ovf) begin errors++; $display("FAIL overflow_ovf: got %0b want 1", ovf_os); end
  endtask

  task automatic test_edge();
    drive(1'b1, 32'h8000_0000, 32'd0);
    checks++;
    if (abs_s !== 32'h8000_0000) begin errors++; $display("FAIL edge_abs: got %h want 80000000", abs_s); end
    checks++;
    if (ovf_os !== 1'b0) begin errors++; $display("FAIL edge_ovf: got %0b want 0", ovf_os); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xv, yv, ev;
    int stream_err;
    stream_err = 0;
    for (int i = 0; i < 100; i++) begin
      xv = $urandom() & 32'hFF;
      yv = $urandom() & 32'hFF;
      ev = (xv < yv) ? (xv / 2 + yv) : (xv + yv / 2);
      drive(1'b1, xv, yv);
      checks++;
      if (abs_s !== ev || valid_os !== 1'b1 || ovf_os !== 1'b0) begin
        errors++;
        stream_err++;
        $display("FAIL stream[%0d] (%0d,%0d): abs=%0d valid=%0b ovf=%0b want abs=%0d valid=1 ovf=0",
                 i, xv, yv, abs_s, valid_os, ovf_os, ev);
      end
    end
    checks++;
    if (stream_err !== 0) begin errors++; $display("FAIL stream_error_count: got %0d want 0", stream_err); end
  endtask

  task automatic test_gaps();
    drive(1'b1, 32'd6, 32'd2);
    checks++;
    if (valid_os !== 1'b1 || abs_s !== 32'd7) begin
      errors++; $display("FAIL gap_first: valid=%0b abs=%0d want 1 7", valid_os, abs_s);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'd100, 32'd100);
      checks++;
      if (valid_os !== 1'b0 || abs_s !== 32'd7 || ovf_os !== 1'b0) begin
        errors++; $display("FAIL gap_idle%0d: valid=%0b abs=%0d ovf=%0b want 0 7 0", i, valid_os, abs_s, ovf_os);
      end
    end
    drive(1'b1, 32'd2, 32'd8);
    checks++;
    if (valid_os !== 1'b1 || abs_s !== 32'd9) begin
      errors++; $display("FAIL gap_last: valid=%0b abs=%0d want 1 9", valid_os, abs_s);
    end
    drive(1'b0, 32'd0, 32'd0);
    checks++;
    if (valid_os !== 1'b0 || abs_s !== 32'd9) begin
      errors++; $display("FAIL gap_tail: valid=%0b abs=%0d want 0 9", valid_os, abs_s);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_ns   = 1'b0;
    valid_is = 1'b0;
    x_s      = '0;
    y_s      = '0;
    repeat (2) @(posedge clk_s);
    @(negedge clk_s);
    rst_ns = 1'b1;

    test_reset();
    test_basic();
    test_overflow();
    test_edge();
    test_back_to_back();
    test_gaps();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_vector_abs
